// File: rtl/prog_timer_n.sv
// prog_timer_n: prescaled up/down step timer with wrap/saturate/reload/one-shot terminal modes
module prog_timer_n #(
    parameter int WIDTH  = 32,
    parameter int STEP_W = 3,
    parameter int PRE_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [WIDTH-1:0]  din,
    input  logic              up_down,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  limit,
    input  logic [WIDTH-1:0]  reload,
    input  logic [PRE_W-1:0]  prescale,
    input  logic              evt_clr,
    output logic [WIDTH-1:0]  count,
    output logic              timer_event,
    output logic              event_sticky,
    output logic              running
);
    localparam logic [1:0] WRAP = 2'd0, SAT = 2'd1, RELOAD = 2'd2, ONESHOT = 2'd3;
    logic [PRE_W-1:0] pre_cnt;
    logic [WIDTH:0]   s, up_sum;
    logic [WIDTH-1:0] term_val, next_cnt;
    logic             pre_hit, tick, term, fire;
    assign s        = (WIDTH+1)'(step) + (WIDTH+1)'(1);
    // the extra carry bit makes an overflow past the top land above any limit
    assign up_sum   = {1'b0, count} + s;
    assign term     = up_down ? (up_sum >= {1'b0, limit}) : ({1'b0, count} <= s);
    assign term_val = mode == RELOAD ? reload :
                      mode == WRAP   ? (up_down ? '0 : limit) :
                                       (up_down ? limit : '0);
    assign pre_hit  = pre_cnt == prescale;
    assign tick     = enable && running && !load && pre_hit;
    assign fire     = tick && term && !(mode == SAT && count == term_val);
    assign next_cnt = term ? term_val : up_down ? up_sum[WIDTH-1:0] : count - s[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (reset) begin
            count        <= '0;
            pre_cnt      <= '0;
            timer_event  <= 1'b0;
            event_sticky <= 1'b0;
            running      <= 1'b1;
        end else begin
            timer_event  <= fire;
            event_sticky <= fire | (event_sticky & ~evt_clr);
            if (load) begin
                count   <= din;
                pre_cnt <= '0;
                running <= 1'b1;
            end else if (enable && running) begin
                pre_cnt <= pre_hit ? '0 : pre_cnt + PRE_W'(1);
                if (pre_hit) count <= next_cnt;
                if (tick && term && mode == ONESHOT) running <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_prog_timer_n.sv
// tb_prog_timer_n: directed vector table plus randomized run against an arithmetic reference model
module tb_prog_timer_n;
    logic       clk = 0, reset = 1, enable = 0, load = 0, up_down = 0, evt_clr = 0;
    logic [7:0] din = 0, limit = 0, reload = 0, prescale = 0, count;
    logic [2:0] step = 0;
    logic [1:0] mode = 0;
    logic       timer_event, event_sticky, running;
    int checks = 0, errors = 0;
    int m_cnt, m_pre;
    bit m_ev, m_st, m_run;

    prog_timer_n #(.WIDTH(8), .STEP_W(3), .PRE_W(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .din(din),
        .up_down(up_down), .step(step), .mode(mode), .limit(limit), .reload(reload),
        .prescale(prescale), .evt_clr(evt_clr), .count(count), .timer_event(timer_event),
        .event_sticky(event_sticky), .running(running)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst, ld, en, up, clr;
        bit [1:0] md;
        bit [2:0] st;
        bit [7:0] din, lim, rel, pre;
        int ec;
        bit eev, est, erun;
    } vec_t;
    vec_t tbl[$];
    vec_t cur;

    task automatic add(input int ec, input bit eev, input bit est, input bit erun);
        cur.ec = ec; cur.eev = eev; cur.est = est; cur.erun = erun;
        tbl.push_back(cur);
        cur.rst = 0; cur.ld = 0; cur.clr = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // reference: timer rules evaluated with plain integer arithmetic on the inputs of this cycle
    task automatic model_step();
        int s, tgt;
        bit fire;
        fire = 0;
        if (reset) begin
            m_cnt = 0; m_pre = 0; m_ev = 0; m_st = 0; m_run = 1;
        end else begin
            if (load) begin
                m_cnt = int'(din); m_pre = 0; m_run = 1;
            end else if (enable && m_run) begin
                if (m_pre == int'(prescale)) begin
                    m_pre = 0;
                    s = int'(step) + 1;
                    if (up_down ? (m_cnt + s >= int'(limit)) : (m_cnt <= s)) begin
                        case (mode)
                            2'd0: tgt = up_down ? 0 : int'(limit);
                            2'd2: tgt = int'(reload);
                            default: tgt = up_down ? int'(limit) : 0;
                        endcase
                        fire = !(mode == 2'd1 && m_cnt == tgt);
                        m_cnt = tgt;
                        if (mode == 2'd3) m_run = 0;
                    end else m_cnt = up_down ? m_cnt + s : m_cnt - s;
                end else m_pre++;
            end
            m_st = fire | (m_st & !evt_clr);
            m_ev = fire;
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        cur = '{default: 0};
        cur.rst = 1; add(0, 0, 0, 1);
        // wrap up by 1 to limit 5
        cur.en = 1; cur.up = 1; cur.lim = 5;
        add(1, 0, 0, 1); add(2, 0, 0, 1); add(3, 0, 0, 1); add(4, 0, 0, 1);
        add(0, 1, 1, 1); add(1, 0, 1, 1);
        cur.clr = 1; add(2, 0, 0, 1);
        // saturate down by 3 from 10
        cur.ld = 1; cur.din = 10; cur.md = 1; cur.up = 0; cur.st = 2; add(10, 0, 0, 1);
        add(7, 0, 0, 1); add(4, 0, 0, 1); add(1, 0, 0, 1); add(0, 1, 1, 1); add(0, 0, 1, 1);
        cur.clr = 1; add(0, 0, 0, 1);
        // reload up by 8, limit 20, reload 3
        cur.ld = 1; cur.din = 0; cur.md = 2; cur.up = 1; cur.st = 7; cur.lim = 20; cur.rel = 3;
        add(0, 0, 0, 1);
        add(8, 0, 0, 1); add(16, 0, 0, 1); add(3, 1, 1, 1); add(11, 0, 1, 1); add(19, 0, 1, 1);
        add(3, 1, 1, 1);
        cur.clr = 1; cur.en = 0; add(3, 0, 0, 1);
        // one-shot with prescale 3
        cur.ld = 1; cur.md = 3; cur.st = 0; cur.lim = 2; cur.pre = 3; add(0, 0, 0, 1);
        cur.en = 1;
        for (int i = 0; i < 3; i++) add(0, 0, 0, 1);
        add(1, 0, 0, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 0, 1);
        add(2, 1, 1, 0); add(2, 0, 1, 0); add(2, 0, 1, 0);
        cur.ld = 1; cur.clr = 1; add(0, 0, 0, 1);
        // carry-out terminal at top of range, then load beating a terminal tick
        cur.en = 0; cur.ld = 1; cur.din = 250; cur.md = 0; cur.st = 7; cur.lim = 255; cur.pre = 0;
        add(250, 0, 0, 1);
        cur.en = 1; add(0, 1, 1, 1);
        cur.en = 0; cur.ld = 1; add(250, 0, 1, 1);
        cur.en = 1; cur.ld = 1; cur.din = 100; add(100, 0, 1, 1);
        // reset mid-prescale with clear asserted, then prescaler must restart from zero
        cur.en = 0; cur.ld = 1; cur.din = 0; cur.st = 0; cur.pre = 5; add(0, 0, 1, 1);
        cur.en = 1; add(0, 0, 1, 1); add(0, 0, 1, 1);
        cur.rst = 1; cur.clr = 1; add(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(0, 0, 0, 1);
        add(1, 0, 0, 1);
        // event and clear in the same cycle: set wins
        cur.pre = 0; cur.lim = 2; cur.clr = 1; add(0, 1, 1, 1);
        cur.clr = 1; add(1, 0, 0, 1);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; load = tbl[i].ld; enable = tbl[i].en; up_down = tbl[i].up;
            evt_clr = tbl[i].clr; mode = tbl[i].md; step = tbl[i].st; din = tbl[i].din;
            limit = tbl[i].lim; reload = tbl[i].rel; prescale = tbl[i].pre;
            cycle();
            chk($sformatf("vec%0d count", i), int'(count), tbl[i].ec);
            chk($sformatf("vec%0d timer_event", i), int'(timer_event), int'(tbl[i].eev));
            chk($sformatf("vec%0d event_sticky", i), int'(event_sticky), int'(tbl[i].est));
            chk($sformatf("vec%0d running", i), int'(running), int'(tbl[i].erun));
        end

        for (int i = 0; i < 600; i++) begin
            reset   = ($urandom % 80) == 0;
            load    = ($urandom % 15) == 0;
            enable  = ($urandom % 5) != 0;
            evt_clr = ($urandom % 6) == 0;
            din     = 8'($urandom);
            if (($urandom % 20) == 0) begin
                up_down  = 1'($urandom);
                mode     = 2'($urandom);
                step     = 3'($urandom);
                limit    = ($urandom % 3 == 0) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 60));
                reload   = 8'($urandom_range(0, 60));
                prescale = ($urandom % 2 == 0) ? 8'd0 : 8'($urandom_range(1, 3));
            end
            cycle();
            chk("rnd count", int'(count), m_cnt);
            chk("rnd timer_event", int'(timer_event), int'(m_ev));
            chk("rnd event_sticky", int'(event_sticky), int'(m_st));
            chk("rnd running", int'(running), int'(m_run));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
